// File: rtl/cook_scheduler_pkg.sv
// Shared definitions for the microwave cook-cycle controller: state
// encodings, BCD digit limits and power-level helper.
package cook_defs;

  localparam int DIGIT_W = 4;

  localparam logic [DIGIT_W-1:0] MAX_DIGIT     = 4'd9;
  localparam logic [DIGIT_W-1:0] MAX_SEC_TENS  = 4'd5;
  localparam logic [3:0]         DEFAULT_POWER = 4'd10;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_COOK  = 2'd1,
    ST_PAUSE = 2'd2,
    ST_DONE  = 2'd3
  } cook_state_e;

  // Out-of-range power settings (0 or above 10) mean full power.
  function automatic logic [3:0] power_effective(input logic [3:0] lvl);
    return ((lvl == 4'd0) || (lvl > DEFAULT_POWER)) ? DEFAULT_POWER : lvl;
  endfunction

endpackage

// File: rtl/cook_scheduler_bcd_down_timer.sv
// Four-digit BCD mm:ss register with keypad shift-load, clear and
// one-second decrement with borrow. Seconds above 59 count down as entered.
module bcd_down_timer
  import cook_defs::*;
(
  input  logic               clk,
  input  logic               resetn,
  input  logic               load,
  input  logic               clear,
  input  logic               dec,
  input  logic [DIGIT_W-1:0] load_digit,
  output logic [DIGIT_W-1:0] min_tens,
  output logic [DIGIT_W-1:0] min_ones,
  output logic [DIGIT_W-1:0] sec_tens,
  output logic [DIGIT_W-1:0] sec_ones,
  output logic               is_zero,
  output logic               is_one
);

  logic [DIGIT_W-1:0] mt_q, mt_d, mo_q, mo_d, st_q, st_d, so_q, so_d;

  // Digit register with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      mt_q <= '0;
      mo_q <= '0;
      st_q <= '0;
      so_q <= '0;
    end else begin
      mt_q <= mt_d;
      mo_q <= mo_d;
      st_q <= st_d;
      so_q <= so_d;
    end
  end

  // Clear wins over load, load over decrement; decrement never wraps below 00:00.
  always_comb begin
    mt_d = mt_q;
    mo_d = mo_q;
    st_d = st_q;
    so_d = so_q;
    if (clear) begin
      mt_d = '0;
      mo_d = '0;
      st_d = '0;
      so_d = '0;
    end else if (load) begin
      mt_d = mo_q;
      mo_d = st_q;
      st_d = so_q;
      so_d = load_digit;
    end else if (dec && !is_zero) begin
      if (so_q != '0) begin
        so_d = so_q - 4'd1;
      end else if (st_q != '0) begin
        st_d = st_q - 4'd1;
        so_d = MAX_DIGIT;
      end else begin
        st_d = MAX_SEC_TENS;
        so_d = MAX_DIGIT;
        if (mo_q != '0) begin
          mo_d = mo_q - 4'd1;
        end else begin
          mo_d = MAX_DIGIT;
          mt_d = mt_q - 4'd1;
        end
      end
    end
  end

  assign min_tens = mt_q;
  assign min_ones = mo_q;
  assign sec_tens = st_q;
  assign sec_ones = so_q;
  assign is_zero  = (mt_q == '0) && (mo_q == '0) && (st_q == '0) && (so_q == '0);
  assign is_one   = (mt_q == '0) && (mo_q == '0) && (st_q == '0) && (so_q == 4'd1);

endmodule

// File: rtl/cook_scheduler.sv
// Cook-cycle controller: button edge detection, IDLE/COOK/PAUSE/DONE FSM,
// one-second prescaler, power-modulation phase and magnetron enable.
module cook_scheduler
  import cook_defs::*;
#(
  parameter int TICKS_PER_SEC = 100,
  parameter int DUTY_PERIOD   = 10
) (
  input  logic               clk,
  input  logic               resetn,
  input  logic               startn,
  input  logic               stopn,
  input  logic               clearn,
  input  logic               door_closed,
  input  logic               load_en,
  input  logic [3:0]         load_digit,
  input  logic [3:0]         power_level,
  output logic               mag_on,
  output logic               timer_done,
  output logic               beep,
  output logic [1:0]         state,
  output logic [DIGIT_W-1:0] min_tens,
  output logic [DIGIT_W-1:0] min_ones,
  output logic [DIGIT_W-1:0] sec_tens,
  output logic [DIGIT_W-1:0] sec_ones
);

  localparam int PRE_W = (TICKS_PER_SEC > 1) ? $clog2(TICKS_PER_SEC) : 1;
  localparam int PH_W  = (DUTY_PERIOD > 1) ? $clog2(DUTY_PERIOD) : 1;
  localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(TICKS_PER_SEC - 1);
  localparam logic [PH_W-1:0]  PH_LAST  = PH_W'(DUTY_PERIOD - 1);

  cook_state_e      state_q, state_d;
  logic [PRE_W-1:0] pre_q, pre_d;
  logic [PH_W-1:0]  phase_q, phase_d;
  logic             timer_done_q, timer_done_d;
  logic [2:0]       btn_cur_q, btn_cur_d, btn_prev_q, btn_prev_d;

  logic start_p, stop_p, clear_p, tick;
  logic t_load, t_clear, t_dec, t_zero, t_one;

  // Button bit order is {clear, stop, start}; a press is a registered 1->0 edge.
  assign btn_cur_d  = {clearn, stopn, startn};
  assign btn_prev_d = btn_cur_q;
  assign start_p    = btn_prev_q[0] & ~btn_cur_q[0];
  assign stop_p     = btn_prev_q[1] & ~btn_cur_q[1];
  assign clear_p    = btn_prev_q[2] & ~btn_cur_q[2];
  assign tick       = (pre_q == PRE_LAST);

  // State, counters and button history with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q      <= ST_IDLE;
      pre_q        <= '0;
      phase_q      <= '0;
      timer_done_q <= 1'b0;
      btn_cur_q    <= '1;
      btn_prev_q   <= '1;
    end else begin
      state_q      <= state_d;
      pre_q        <= pre_d;
      phase_q      <= phase_d;
      timer_done_q <= timer_done_d;
      btn_cur_q    <= btn_cur_d;
      btn_prev_q   <= btn_prev_d;
    end
  end

  // Next-state logic and timer strobes; clear beats stop beats start.
  always_comb begin
    state_d      = state_q;
    pre_d        = pre_q;
    phase_d      = phase_q;
    timer_done_d = 1'b0;
    t_load       = 1'b0;
    t_clear      = 1'b0;
    t_dec        = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (clear_p || stop_p) begin
          t_clear = 1'b1;
        end else if (start_p && door_closed && !t_zero) begin
          state_d = ST_COOK;
          pre_d   = '0;
          phase_d = '0;
        end else if (load_en && (load_digit <= MAX_DIGIT)) begin
          t_load = 1'b1;
        end
      end
      ST_COOK: begin
        if (clear_p) begin
          state_d = ST_IDLE;
          t_clear = 1'b1;
        end else if (stop_p || !door_closed) begin
          state_d = ST_PAUSE;
        end else if (tick) begin
          pre_d   = '0;
          phase_d = (phase_q == PH_LAST) ? '0 : phase_q + PH_W'(1);
          t_dec   = 1'b1;
          if (t_one) begin
            state_d      = ST_DONE;
            timer_done_d = 1'b1;
          end
        end else begin
          pre_d = pre_q + PRE_W'(1);
        end
      end
      ST_PAUSE: begin
        if (clear_p || stop_p) begin
          state_d = ST_IDLE;
          t_clear = 1'b1;
        end else if (start_p && door_closed) begin
          state_d = ST_COOK;
        end
      end
      ST_DONE: begin
        if (clear_p || stop_p || !door_closed) begin
          state_d = ST_IDLE;
          t_clear = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  bcd_down_timer u_timer (
    .clk        (clk),
    .resetn     (resetn),
    .load       (t_load),
    .clear      (t_clear),
    .dec        (t_dec),
    .load_digit (load_digit),
    .min_tens   (min_tens),
    .min_ones   (min_ones),
    .sec_tens   (sec_tens),
    .sec_ones   (sec_ones),
    .is_zero    (t_zero),
    .is_one     (t_one)
  );

  // Raw door input gates the magnetron so opening the door cuts it immediately.
  assign mag_on     = (state_q == ST_COOK) && door_closed &&
                      (32'(phase_q) < 32'(power_effective(power_level)));
  assign timer_done = timer_done_q;
  assign beep       = (state_q == ST_DONE);
  assign state      = state_q;

endmodule
